nibble_pair_rx: RTL and testbench

Receive-side companion to the nibble select/merge datapath. It accepts a byte stream in which each byte carries one 4-bit nibble, a lane tag (A or B) and a half flag. It reassembles the nibbles into 8-bit A and B words and presents completed words on a valid/ready output with round-robin lane arbitration. It sits between the pad-side input byte stream and the downstream consumer in the same single-clock tile.

---
 rtl/nibble_pair_rx_if.sv | 31 +++
 rtl/nibble_pair_rx.sv | 146 ++++++++++++++
 tb/tb_nibble_pair_rx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_pair_rx_if.sv
// nibble_pair_rx_if: byte-in / word-out stream bundle for nibble_pair_rx.
// master drives in_data/in_valid/out_ready, slave (the receiver) drives the rest.
interface nibble_pair_rx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_lane;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_lane,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_lane,
        output out_valid
    );
endinterface

// File: rtl/nibble_pair_rx.sv
// nibble_pair_rx: reassembles tagged nibbles into 8-bit A/B lane words and
// emits them on a valid/ready output with round-robin lane arbitration.
// Ports: clk, rst (sync, active-high), bus (slave: in_* byte stream, out_* words),
//        err (one-cycle pulse per bad byte), err_count (saturating error count).
// Build option: define NIBBLE_PAIR_RX_ERRCNT_EN to enable err_count; else it reads 0.
module nibble_pair_rx (
    input  logic           clk,
    input  logic           rst,
    nibble_pair_rx_if.slave bus,
    output logic           err,
    output logic [7:0]     err_count
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HAVE_LO = 2'd1,
        FULL    = 2'd2
    } lane_st_t;

    // index 0 = lane A, index 1 = lane B
    lane_st_t   st   [2];
    logic [3:0] lo   [2];
    logic [7:0] word [2];

    // set when lane B wins the next tie
    logic       prio_b;

    logic [7:0] out_data_q;
    logic       out_lane_q;
    logic       out_valid_q;

    logic       in_lane;
    logic       in_half;
    logic       rsv_bad;
    logic [3:0] nib;
    lane_st_t   cur_st;
    logic       acc;
    logic       seq_bad;
    logic       err_next;
    logic       full_a;
    logic       full_b;
    logic       out_free;
    logic       load;
    logic       sel;

    assign in_lane = bus.in_data[7];
    assign in_half = bus.in_data[6];
    assign rsv_bad = |bus.in_data[5:4];
    assign nib     = bus.in_data[3:0];

    // ready only looks at the addressed lane's registered state
    assign cur_st       = st[in_lane];
    assign bus.in_ready = (cur_st != FULL);
    assign acc          = bus.in_valid & bus.in_ready;

    always_comb begin
        seq_bad = 1'b0;
        unique case (cur_st)
            EMPTY:   seq_bad = in_half;
            HAVE_LO: seq_bad = ~in_half;
            default: seq_bad = 1'b0;
        endcase
    end

    // reserved and sequence faults on one byte collapse into one pulse
    assign err_next = acc & (rsv_bad | seq_bad);

    assign full_a   = (st[0] == FULL);
    assign full_b   = (st[1] == FULL);
    assign out_free = ~out_valid_q | bus.out_ready;
    assign load     = out_free & (full_a | full_b);
    assign sel      = (full_a & full_b) ? prio_b : full_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                st[l]   <= EMPTY;
                lo[l]   <= 4'h0;
                word[l] <= 8'h00;
            end
            prio_b      <= 1'b0;
            out_data_q  <= 8'h00;
            out_lane_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= err_next;

            // a FULL lane never accepts input, so drain and fill never collide
            for (int l = 0; l < 2; l++) begin
                if (load && (sel == l[0])) begin
                    st[l] <= EMPTY;
                end else if (acc && !rsv_bad && (in_lane == l[0])) begin
                    unique case (st[l])
                        EMPTY: begin
                            if (!in_half) begin
                                lo[l] <= nib;
                                st[l] <= HAVE_LO;
                            end
                        end
                        HAVE_LO: begin
                            if (in_half) begin
                                word[l] <= {nib, lo[l]};
                                st[l]   <= FULL;
                            end else begin
                                lo[l] <= nib;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (load) begin
                out_data_q  <= word[sel];
                out_lane_q  <= sel;
                out_valid_q <= 1'b1;
                // the lane just served loses the next tie
                prio_b      <= ~sel;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.out_valid = out_valid_q;

`ifdef NIBBLE_PAIR_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_nibble_pair_rx.sv
// tb_nibble_pair_rx: directed scoreboard bench for nibble_pair_rx.
// Expected words are queued by the stimulus and checked on each output handshake.
module tb_nibble_pair_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       err;
    logic [7:0] err_count;

    nibble_pair_rx_if bus ();

    nibble_pair_rx dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int         checks     = 0;
    int         errors     = 0;
    int         err_pulses = 0;
    int         exp_errs   = 0;
    int         exp_cnt    = 0;
    logic [8:0] sb [$];
    logic [8:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // output scoreboard and err pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        if (err === 1'b1) err_pulses++;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL out_unexpected: observed lane %0d data %0h expected none",
                       bus.out_lane, bus.out_data);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checks++;
                assert ({bus.out_lane, bus.out_data} === mon_exp) else begin
                    errors++;
                    $error("FAIL out_word: observed %0h expected %0h",
                           {bus.out_lane, bus.out_data}, mon_exp);
                end
            end
        end
    end

    // entered and left at posedge+1; handshake on the first edge with ready
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic bump_err();
        exp_errs++;
`ifdef NIBBLE_PAIR_RX_ERRCNT_EN
        if (exp_cnt < 255) exp_cnt++;
`endif
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
        chk("drain_queue", sb.size(), 0);
        chk("err_pulses", err_pulses, exp_errs);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_lane", bus.out_lane, 0);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        @(posedge clk);
        #1;

        // basic reassembly and latency
        sb.push_back({1'b0, 8'hA5});
        send(8'h05);
        send(8'h4A);
        chk("basic_n1_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("basic_n2_valid", bus.out_valid, 1);
        chk("basic_n2_data", bus.out_data, 8'hA5);
        chk("basic_n2_lane", bus.out_lane, 0);
        chk("basic_err", err, 0);
        drain();

        // interleaved lanes
        sb.push_back({1'b1, 8'h73});
        sb.push_back({1'b0, 8'h21});
        send(8'h83);
        send(8'h01);
        send(8'hC7);
        send(8'h42);
        drain();

        // backpressure
        bus.out_ready = 1'b0;
        sb.push_back({1'b0, 8'h21});
        sb.push_back({1'b0, 8'h43});
        send(8'h01);
        send(8'h42);
        send(8'h03);
        send(8'h44);
        bus.in_data = 8'h05;
        #1;
        chk("bp_ready_a_full", bus.in_ready, 0);
        bus.in_data = 8'h81;
        #1;
        chk("bp_ready_b", bus.in_ready, 1);
        bus.in_data = 8'h00;
        @(negedge clk);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_data", bus.out_data, 8'h21);
        @(negedge clk);
        chk("bp_hold_data2", bus.out_data, 8'h21);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'h05);
        chk("bp_order_done", sb.size(), 0);
        drain();

        // error handling and saturation
        do_reset();
        send(8'h45);
        bump_err();
        chk("err_empty_hi", err, 1);
        @(posedge clk);
        #1;
        chk("err_pulse_width", err, 0);
        chk("err_count_1", err_count, exp_cnt);
        send(8'h15);
        bump_err();
        chk("err_reserved", err, 1);
        @(posedge clk);
        #1;
        chk("err_count_2", err_count, exp_cnt);
        sb.push_back({1'b0, 8'h94});
        send(8'h03);
        send(8'h04);
        bump_err();
        chk("err_lo_twice", err, 1);
        send(8'h49);
        chk("err_good_hi", err, 0);
        @(posedge clk);
        #1;
        chk("err_count_3", err_count, exp_cnt);
        drain();
        for (int i = 0; i < 256; i++) begin
            send(8'h45);
            bump_err();
        end
        @(posedge clk);
        #1;
        chk("err_count_sat", err_count, exp_cnt);
        drain();

        // tie arbitration: B occupies the output, then A wins the tie
        do_reset();
        bus.out_ready = 1'b0;
        sb.push_back({1'b1, 8'h55});
        send(8'h85);
        send(8'hC5);
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b1, 8'h22});
        send(8'h01);
        send(8'h41);
        send(8'h82);
        send(8'hC2);
        bus.in_data = 8'h00;
        #1;
        chk("tie1_a_full", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        drain();

        // A served last, so B wins this tie
        bus.out_ready = 1'b0;
        sb.push_back({1'b0, 8'h66});
        send(8'h06);
        send(8'h46);
        sb.push_back({1'b1, 8'h22});
        sb.push_back({1'b0, 8'h11});
        send(8'h01);
        send(8'h41);
        send(8'h82);
        send(8'hC2);
        bus.in_data = 8'h80;
        #1;
        chk("tie2_b_full", bus.in_ready, 0);
        bus.in_data = 8'h00;
        bus.out_ready = 1'b1;
        drain();

        // reset mid-operation drops the partial low nibble
        do_reset();
        send(8'h07);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        send(8'h4F);
        bump_err();
        chk("rstmid_err", err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_no_out", bus.out_valid, 0);
        chk("rstmid_err_count", err_count, exp_cnt);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
